// File: rtl/coherence_pkg.sv
// coherence_pkg: controller states plus index-width and block-offset helpers shared by the snoop controller and arbiter
package coherence_pkg;
  typedef enum logic [2:0] {IDLE, SNOOP, FWD, MEMRD, WB, INV, DONE} state_e;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int blk_off(input int blkwords);
    return $clog2(blkwords) + 2;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant over an N-wide request vector; ports: clk, rst_n (async low), req, en (take grant) in; gnt_vld, gnt_idx out
module rr_arbiter import coherence_pkg::*; #(
  parameter int N = 2,
  localparam int IW = idx_w(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic          gnt_vld,
  output logic [IW-1:0] gnt_idx
);
  logic [IW-1:0] ptr_q, ptr_d, j;
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = ptr_q;
    j = '0;
    for (int k = N; k >= 1; k--) begin
      j = IW'((int'(ptr_q) + k) % N);
      if (req[j]) begin
        gnt_vld = 1'b1;
        gnt_idx = j;
      end
    end
    ptr_d = (en && gnt_vld) ? gnt_idx : ptr_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_q <= IW'(N - 1);
    else ptr_q <= ptr_d;
endmodule

// File: rtl/snoop_bus_controller.sv
// snoop_bus_controller: N-cache snooping coherence controller; ports: per-cache dREN/dWEN/ccwrite/cctrans/daddr/dstore in, dwait/dload/ccwait/ccinv/ccsnoopaddr out, single memory port mem_*
module snoop_bus_controller import coherence_pkg::*; #(
  parameter int NCACHE   = 2,
  parameter int BLKWORDS = 2,
  parameter int WORD_W   = 32
) (
  input  logic                           CLK,
  input  logic                           nRST,
  input  logic [NCACHE-1:0]              dREN,
  input  logic [NCACHE-1:0]              dWEN,
  input  logic [NCACHE-1:0]              ccwrite,
  input  logic [NCACHE-1:0]              cctrans,
  input  logic [NCACHE-1:0][WORD_W-1:0]  daddr,
  input  logic [NCACHE-1:0][WORD_W-1:0]  dstore,
  output logic [NCACHE-1:0]              dwait,
  output logic [NCACHE-1:0][WORD_W-1:0]  dload,
  output logic [NCACHE-1:0]              ccwait,
  output logic [NCACHE-1:0]              ccinv,
  output logic [NCACHE-1:0][WORD_W-1:0]  ccsnoopaddr,
  output logic                           mem_ren,
  output logic                           mem_wen,
  output logic [WORD_W-1:0]              mem_addr,
  output logic [WORD_W-1:0]              mem_store,
  input  logic [WORD_W-1:0]              mem_load,
  input  logic                           mem_wait
);
  localparam int IW = idx_w(NCACHE);
  localparam int WI = idx_w(BLKWORDS);
  localparam int OB = blk_off(BLKWORDS);
  state_e state_q, state_d;
  logic [IW-1:0] req_q, req_d, sup_q, sup_d, gnt_idx, snp_idx;
  logic [WI-1:0] widx_q, widx_d, widx_nx;
  logic rfo_q, rfo_d, gnt_vld, last;
  logic [NCACHE-1:0] pending, others;
  logic [WORD_W-1:0] waddr;
  assign pending = cctrans & (dREN | dWEN | ccwrite);
  assign others = ~(NCACHE'(1) << req_q);
  assign waddr = (daddr[req_q] & ~WORD_W'((1 << OB) - 1)) | (WORD_W'(widx_q) << 2);
  assign last = widx_q == WI'(BLKWORDS - 1);
  assign widx_nx = last ? '0 : widx_q + 1'b1;
  rr_arbiter #(.N(NCACHE)) u_arb (
    .clk(CLK), .rst_n(nRST), .req(pending), .en(state_q == IDLE), .gnt_vld(gnt_vld), .gnt_idx(gnt_idx)
  );
  always_comb begin
    state_d = state_q;
    req_d = req_q;
    sup_d = sup_q;
    widx_d = widx_q;
    rfo_d = rfo_q;
    dwait = '1;
    ccwait = '0;
    ccinv = '0;
    dload = '0;
    ccsnoopaddr = '0;
    mem_ren = 1'b0;
    mem_wen = 1'b0;
    mem_addr = '0;
    mem_store = '0;
    snp_idx = '0;
    for (int i = NCACHE - 1; i >= 0; i--)
      if (ccwrite[i] && others[i]) snp_idx = IW'(i);
    case (state_q)
      IDLE: if (gnt_vld) begin
        req_d = gnt_idx;
        rfo_d = ccwrite[gnt_idx];
        state_d = dWEN[gnt_idx] ? WB : dREN[gnt_idx] ? SNOOP : INV;
      end
      SNOOP: begin
        ccwait = others;
        for (int i = 0; i < NCACHE; i++) ccsnoopaddr[i] = others[i] ? waddr : '0;
        sup_d = snp_idx;
        state_d = |(ccwrite & others) ? FWD : MEMRD;
      end
      FWD: begin
        mem_wen = 1'b1;
        mem_addr = waddr;
        mem_store = dstore[sup_q];
        dload[req_q] = dstore[sup_q];
        ccwait[sup_q] = 1'b1;
        ccsnoopaddr[sup_q] = waddr;
        if (!mem_wait) begin
          dwait[req_q] = 1'b0;
          dwait[sup_q] = 1'b0;
          widx_d = widx_nx;
          state_d = last ? DONE : FWD;
        end
      end
      MEMRD: begin
        mem_ren = 1'b1;
        mem_addr = waddr;
        if (!mem_wait) begin
          dload[req_q] = mem_load;
          dwait[req_q] = 1'b0;
          widx_d = widx_nx;
          state_d = last ? DONE : MEMRD;
        end
      end
      WB: begin
        mem_wen = 1'b1;
        mem_addr = waddr;
        mem_store = dstore[req_q];
        if (!mem_wait) begin
          dwait[req_q] = 1'b0;
          widx_d = widx_nx;
          state_d = last ? IDLE : WB;
        end
      end
      INV: begin
        ccinv = others;
        dwait[req_q] = 1'b0;
        state_d = IDLE;
      end
      DONE: begin
        ccinv = rfo_q ? others : '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state_q <= IDLE;
      req_q <= '0;
      sup_q <= '0;
      widx_q <= '0;
      rfo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q <= req_d;
      sup_q <= sup_d;
      widx_q <= widx_d;
      rfo_q <= rfo_d;
    end
endmodule
